// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited prefetch front end with redirect flush; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] fetch_pc_q, fetch_pc_d, pc_tag_q, pc_tag_d, tgt;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pcs_q [FIFO_DEPTH];
  logic run_q, acc, push, pop;
  logic [CW:0] used;
  assign tgt = redirect_pc & ~32'd3;
  // Buffered plus in-flight words never exceed the FIFO, so a push can never overflow
  assign used = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = run_q && !redirect_valid && used < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = fetch_pc_q;
  assign acc = imem_req_valid && imem_req_ready;
  assign instr_valid = cnt_q != '0;
  assign instr = instr_valid ? data_q[rd_q] : '0;
  assign instr_pc = instr_valid ? pcs_q[rd_q] : '0;
  assign push = imem_rsp_valid && drop_q == '0 && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  always_comb begin
    out_d = out_q + CW'(acc) - CW'(imem_rsp_valid);
    drop_d = redirect_valid ? out_d : drop_q - CW'(imem_rsp_valid && drop_q != '0);
    cnt_d = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + AW'(push);
    fetch_pc_d = redirect_valid ? tgt : acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    pc_tag_d = redirect_valid ? tgt : push ? pc_tag_q + 32'd4 : pc_tag_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pc_tag_q <= RESET_PC;
      cnt_q <= '0;
      out_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      run_q <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      pc_tag_q <= pc_tag_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_rsp_data;
      pcs_q[wr_q] <= pc_tag_q;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_flush_cnt <= perf_flush_cnt + 32'(redirect_valid);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: phase table plus scoreboard of expected {pc, word} for the fetch unit
module tb_instr_fetch_unit;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0, instr, instr_pc;
  logic        redirect_valid = 0, instr_valid, instr_ready = 0;
  logic        w_req_valid, w_rsp_valid = 0, w_instr_valid;
  logic [31:0] w_req_addr, w_rsp_data = 0, w_instr, w_instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_perf_fetch, w_perf_flush;
`endif
  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_flush_cnt(w_perf_flush)
`endif
  );

  typedef struct {logic [31:0] a; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
  typedef struct {
    bit rst; int n; bit in_rdy; bit mem_rdy; bit rnd; int lat; bit redir; logic [31:0] rpc;
    int ex_acc; int ex_pop; int ex_rv; int ex_iv;
  } vec_t;

  mreq_t mq[$];
  ent_t sb[$];
  vec_t tbl[16];
  int tests = 0, fails = 0, cyc = 0, lat = 1, acc_n = 0, pop_n = 0, w_pops = 0;
  int exp_fetch = 0, exp_flush = 0;
  bit in_rdy_v = 0, mem_rdy_v = 0, rnd = 0, prev_redir = 0, prev_stall = 0, w_pend = 0;
  logic last_rv, last_iv;
  logic [31:0] exp_pc = 0, prev_addr = 0, w_pend_a = 0, w_exp = 32'hFFFF_FFF8;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_perf();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, exp_fetch);
    chk("perf_flush", perf_flush_cnt, exp_flush);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_w_req_valid", w_req_valid, 0);
    chk("rst_w_req_addr", w_req_addr, 32'hFFFF_FFF8);
    chk("rst_w_instr_valid", w_instr_valid, 0);
    exp_fetch = 0;
    exp_flush = 0;
    chk_perf();
    mq.delete();
    sb.delete();
    exp_pc = 0;
    prev_redir = 0;
    prev_stall = 0;
    redirect_valid = 0;
    imem_rsp_valid = 0;
    w_rsp_valid = 0;
    w_pend = 0;
    w_exp = 32'hFFFF_FFF8;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic tick(input bit redir, input logic [31:0] rpc);
    ent_t e;
    @(negedge clk);
    instr_ready = rnd ? ($urandom_range(0, 3) != 0) : in_rdy_v;
    imem_req_ready = rnd ? ($urandom_range(0, 2) != 0) : mem_rdy_v;
    redirect_valid = redir;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = word(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
    end
    w_rsp_valid = w_pend;
    w_rsp_data = word(w_pend_a);
    #1;
    last_rv = imem_req_valid;
    last_iv = instr_valid;
    if (prev_redir) chk("valid_after_redirect", instr_valid, 0);
    if (redir) chk("req_blocked_by_redirect", imem_req_valid, 0);
    if (prev_stall && !redir) begin
      chk("stall_hold_valid", imem_req_valid, 1);
      chk("stall_hold_addr", imem_req_addr, prev_addr);
    end
    if (instr_valid && instr_ready && !redir) begin
      pop_n++;
      exp_fetch++;
      if (sb.size() == 0) chk("pop_unexpected", instr_pc, 32'hDEAD_BEEF);
      else begin
        e = sb.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_data", instr, e.d);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      mq.push_back('{imem_req_addr, cyc + lat});
      sb.push_back('{exp_pc, word(exp_pc)});
      exp_pc += 4;
      acc_n++;
    end
    if (redir) begin
      sb.delete();
      exp_pc = rpc & ~32'd3;
      exp_flush++;
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr = imem_req_addr;
    prev_redir = redir;
    if (w_instr_valid) begin
      chk("wrap_pc", w_instr_pc, w_exp);
      chk("wrap_data", w_instr, word(w_exp));
      w_exp += 4;
      w_pops++;
    end
    w_pend = w_req_valid;
    w_pend_a = w_req_addr;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    //          rst  n  in mem rnd lat rd rpc            acc pop rv  iv
    tbl[0]  = '{1, 20, 0, 1, 0, 1, 0, 32'h0,          4,  0,  0,  1};
    tbl[1]  = '{0, 12, 1, 1, 0, 1, 0, 32'h0,          11, 12, 1,  1};
    tbl[2]  = '{0, 40, 1, 1, 1, 2, 0, 32'h0,          -1, -1, -1, -1};
    tbl[3]  = '{0, 30, 1, 1, 1, 2, 1, 32'h2001,       -1, -1, -1, -1};
    tbl[4]  = '{1, 3,  1, 1, 0, 4, 0, 32'h0,          3,  0,  1,  0};
    tbl[5]  = '{0, 1,  1, 1, 0, 4, 1, 32'h103,        0,  0,  0,  0};
    tbl[6]  = '{0, 15, 1, 1, 0, 4, 0, 32'h0,          -1, -1, -1, -1};
    tbl[7]  = '{1, 3,  1, 1, 0, 3, 0, 32'h0,          3,  0,  1,  0};
    tbl[8]  = '{0, 1,  1, 1, 0, 3, 1, 32'h40,         0,  0,  0,  0};
    tbl[9]  = '{0, 12, 1, 1, 0, 3, 0, 32'h0,          -1, -1, -1, -1};
    tbl[10] = '{0, 2,  1, 1, 0, 1, 0, 32'h0,          -1, -1, -1, -1};
    tbl[11] = '{0, 1,  1, 1, 0, 1, 1, 32'hFFFF_FFF9,  0,  0,  0,  -1};
    tbl[12] = '{0, 10, 1, 1, 0, 1, 0, 32'h0,          -1, -1, -1, -1};
    tbl[13] = '{0, 1,  1, 1, 0, 1, 1, 32'h500,        0,  0,  0,  -1};
    tbl[14] = '{0, 1,  1, 1, 0, 1, 1, 32'h602,        0,  0,  0,  0};
    tbl[15] = '{0, 10, 1, 1, 0, 1, 0, 32'h0,          -1, -1, -1, -1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      in_rdy_v = tbl[i].in_rdy;
      mem_rdy_v = tbl[i].mem_rdy;
      rnd = tbl[i].rnd;
      lat = tbl[i].lat;
      acc_n = 0;
      pop_n = 0;
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].redir && k == 0, tbl[i].rpc);
      if (tbl[i].ex_acc >= 0) chk($sformatf("phase%0d_accepts", i), acc_n, tbl[i].ex_acc);
      if (tbl[i].ex_pop >= 0) chk($sformatf("phase%0d_pops", i), pop_n, tbl[i].ex_pop);
      if (tbl[i].ex_rv >= 0) chk($sformatf("phase%0d_req_valid", i), last_rv, tbl[i].ex_rv);
      if (tbl[i].ex_iv >= 0) chk($sformatf("phase%0d_instr_valid", i), last_iv, tbl[i].ex_iv);
      chk_perf();
    end
    // asynchronous reset between clock edges while the FIFO holds data
    chk("pre_reset_instr_valid", instr_valid, 1);
    chk("wrap_pops_seen", 32'(w_pops >= 3), 1);
    do_reset();
    in_rdy_v = 1;
    mem_rdy_v = 1;
    rnd = 0;
    lat = 1;
    pop_n = 0;
    for (int k = 0; k < 8; k++) tick(0, 0);
    chk("restart_pops", pop_n, 6);
    chk_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
